// File: rtl/seq_divider16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// start/busy/done handshake so decode can stall while an operation is in flight.
module seq_divider16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] dq_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] div_r;
  logic             dbz_r;

  logic [WIDTH:0]   rem_shift_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] dq_step_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = (divisor == {WIDTH{1'b0}}) ? FINISH : RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (count_r == LAST_COUNT) begin
          state_nx_s = FINISH;
        end else begin
          state_nx_s = RUN;
        end
      end
      FINISH:  state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // One restoring step; the partial remainder stays below the divisor, so the
  // shifted value fits in WIDTH+1 bits and the difference fits back in WIDTH.
  always_comb begin
    rem_shift_s = {rem_r, dq_r[WIDTH-1]};
    ge_s        = (rem_shift_s >= {1'b0, div_r});
    if (ge_s) begin
      rem_step_s = rem_shift_s[WIDTH-1:0] - div_r;
    end else begin
      rem_step_s = rem_shift_s[WIDTH-1:0];
    end
    dq_step_s = {dq_r[WIDTH-2:0], ge_s};
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r     <= {CW{1'b0}};
      dq_r        <= {WIDTH{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      div_r       <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= {WIDTH{1'b0}};
      remainder   <= {WIDTH{1'b0}};
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            div_r   <= divisor;
            count_r <= {CW{1'b0}};
            busy    <= 1'b1;
            // Divide-by-zero preloads its fixed result and goes straight to FINISH
            if (divisor == {WIDTH{1'b0}}) begin
              dq_r  <= {WIDTH{1'b1}};
              rem_r <= dividend;
              dbz_r <= 1'b1;
            end else begin
              dq_r  <= dividend;
              rem_r <= {WIDTH{1'b0}};
              dbz_r <= 1'b0;
            end
          end
        end
        RUN: begin
          dq_r    <= dq_step_s;
          rem_r   <= rem_step_s;
          count_r <= count_r + 1'b1;
        end
        FINISH: begin
          quotient    <= dq_r;
          remainder   <= rem_r;
          div_by_zero <= dbz_r;
          done        <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Self-checking bench for seq_divider16: directed vector table, handshake and
// abort sequences, and random pairs, all checked through an expected-result queue.
module tb_seq_divider16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  seq_divider16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
  } vec_t;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst !== 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("latency", cyc - e.acc, e.lat);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  task automatic push_exp(input logic [15:0] q, input logic [15:0] r, input logic z);
    exp_t e;
    e.q = q; e.r = r; e.z = z; e.acc = cyc; e.lat = z ? 1 : 17;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Issue one operation from a negedge, scramble inputs after acceptance, wait for result
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] q, input logic [15:0] r, input logic z);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    push_exp(q, r, z);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    chk("busy_after_accept", busy, 1);
    wait_drain();
  endtask

  function automatic vec_t model(input logic [15:0] a, input logic [15:0] b);
    vec_t v;
    v.a = a; v.b = b;
    if (b == 16'd0) begin
      v.q = 16'hFFFF; v.r = a; v.z = 1'b1;
    end else begin
      v.q = a / b; v.r = a % b; v.z = 1'b0;
    end
    return v;
  endfunction

  vec_t vecs[9];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int saved;
    vec_t v;
    logic [15:0] a;
    logic [15:0] b;
    int sel;

    vecs[0] = '{16'd100,   16'd7,     16'd14,    16'd2,    1'b0};
    vecs[1] = '{16'd65535, 16'd1,     16'd65535, 16'd0,    1'b0};
    vecs[2] = '{16'd65535, 16'd65535, 16'd1,     16'd0,    1'b0};
    vecs[3] = '{16'd5,     16'd9,     16'd0,     16'd5,    1'b0};
    vecs[4] = '{16'd1234,  16'd0,     16'hFFFF,  16'd1234, 1'b1};
    vecs[5] = '{16'd0,     16'd5,     16'd0,     16'd0,    1'b0};
    vecs[6] = '{16'd0,     16'd0,     16'hFFFF,  16'd0,    1'b1};
    vecs[7] = '{16'd32768, 16'd3,     16'd10922, 16'd2,    1'b0};
    vecs[8] = '{16'd40000, 16'd40001, 16'd0,     16'd40000, 1'b0};

    rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
    end

    // Start while busy is ignored; start alongside done is accepted
    dividend = 16'd50; divisor = 16'd5; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(16'd10, 16'd0, 1'b0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 16'd20; divisor = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; dividend = 16'd7; divisor = 16'd2;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done_seen", done, 1);
    dividend = 16'd20; divisor = 16'd4; start = 1'b1;
    @(posedge clk);
    #1;
    push_exp(16'd5, 16'd0, 1'b0);
    start = 1'b0; dividend = 16'd9; divisor = 16'd9;
    chk("b2b_busy", busy, 1);
    wait_drain();

    // Reset mid-run aborts with no done pulse and clears the held results
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    saved = done_cnt;
    repeat (25) @(negedge clk);
    chk("abort_no_done", done_cnt, saved);
    do_op(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 9);
      a = 16'($urandom);
      if (sel == 0) b = 16'd0;
      else if (sel < 4) b = 16'($urandom_range(1, 15));
      else b = 16'($urandom);
      v = model(a, b);
      do_op(v.a, v.b, v.q, v.r, v.z);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
